// File: rtl/hb_udp_responder.sv
// Key/value-address table behind an AXI-Stream request/response pair.
// Requests are served one at a time: linear scan of the table, then commit.
module hb_udp_responder #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_axis_udp_req_tvalid,
    input  logic [143:0]             s_axis_udp_req_tdata,
    output logic                     s_axis_udp_req_tready,
    output logic                     m_axis_udp_res_tvalid,
    output logic [143:0]             m_axis_udp_res_tdata,
    input  logic                     m_axis_udp_res_tready,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [31:0]      OP_INSERT = 32'd0;
    localparam logic [31:0]      OP_DELETE = 32'd1;
    localparam logic [31:0]      OP_LOOKUP = 32'd2;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT, S_RESP} state_t;

    state_t             r_state;
    state_t             w_next;
    logic               w_accept;

    logic [31:0]        r_op;
    logic [63:0]        r_key;
    logic [15:0]        r_addr;
    logic [IDX_W-1:0]   r_idx;
    logic               r_hit;
    logic [IDX_W-1:0]   r_hit_idx;
    logic               r_free;
    logic [IDX_W-1:0]   r_free_idx;

    logic [DEPTH-1:0]   r_valid;
    logic [63:0]        r_key_mem  [DEPTH];
    logic [15:0]        r_addr_mem [DEPTH];
    logic [OCC_W-1:0]   r_occ;

    logic               r_res_tvalid;
    logic [143:0]       r_res_tdata;

    logic               w_match;
    logic               w_ins_ok;
    logic               w_del_ok;
    logic               w_lkp_ok;
    logic [7:0]         w_status;
    logic [15:0]        w_res_addr;

    // Request bits [143:112] carry no meaning for this block.
    logic               w_unused_hi;
    assign w_unused_hi = ^s_axis_udp_req_tdata[143:112];

    // Ready is gated by rst_n so it reads 0 while reset is held.
    assign s_axis_udp_req_tready = rst_n && (r_state == S_IDLE);
    assign m_axis_udp_res_tvalid = r_res_tvalid;
    assign m_axis_udp_res_tdata  = r_res_tdata;
    assign occupancy             = r_occ;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (s_axis_udp_req_tvalid) begin
                    w_accept = 1'b1;
                    w_next   = S_SCAN;
                end
            end
            S_SCAN:   if (r_idx == LAST_IDX) w_next = S_COMMIT;
            S_COMMIT: w_next = S_RESP;
            S_RESP:   if (m_axis_udp_res_tready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    assign w_match    = r_valid[r_idx] && (r_key_mem[r_idx] == r_key);
    assign w_ins_ok   = (r_op == OP_INSERT) && !r_hit && r_free;
    assign w_del_ok   = (r_op == OP_DELETE) && r_hit;
    assign w_lkp_ok   = (r_op == OP_LOOKUP) && r_hit;
    assign w_status   = (w_ins_ok || w_del_ok || w_lkp_ok) ? 8'h01 : 8'h00;
    assign w_res_addr = (w_del_ok || w_lkp_ok) ? r_addr_mem[r_hit_idx] : r_addr;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid      <= '0;
            r_occ        <= '0;
            r_res_tvalid <= 1'b0;
            r_res_tdata  <= '0;
        end else if (r_state == S_COMMIT) begin
            if (w_ins_ok) begin
                r_valid[r_free_idx] <= 1'b1;
                r_occ               <= r_occ + OCC_W'(1);
            end
            if (w_del_ok) begin
                r_valid[r_hit_idx]  <= 1'b0;
                r_occ               <= r_occ - OCC_W'(1);
            end
            r_res_tvalid <= 1'b1;
            r_res_tdata  <= {24'h0, w_status, w_res_addr, r_key, r_op};
        end else if (r_state == S_RESP && m_axis_udp_res_tready) begin
            r_res_tvalid <= 1'b0;
        end
    end

    // NOTE: key/address storage is deliberately not reset; the valid bits alone
    // decide whether an entry exists, so the payload can sit in plain RAM.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op       <= s_axis_udp_req_tdata[31:0];
            r_key      <= s_axis_udp_req_tdata[95:32];
            r_addr     <= s_axis_udp_req_tdata[111:96];
            r_idx      <= '0;
            r_hit      <= 1'b0;
            r_hit_idx  <= '0;
            r_free     <= 1'b0;
            r_free_idx <= '0;
        end else if (r_state == S_SCAN) begin
            if (w_match && !r_hit) begin
                r_hit     <= 1'b1;
                r_hit_idx <= r_idx;
            end
            if (!r_valid[r_idx] && !r_free) begin
                r_free     <= 1'b1;
                r_free_idx <= r_idx;
            end
            r_idx <= r_idx + IDX_W'(1);
        end
        // An interrupted request must leave the table untouched.
        if (rst_n && r_state == S_COMMIT && w_ins_ok) begin
            r_key_mem[r_free_idx]  <= r_key;
            r_addr_mem[r_free_idx] <= r_addr;
        end
    end

endmodule

// File: tb/tb_hb_udp_responder.sv
// Directed bench for hb_udp_responder: insert/delete/lookup, full table,
// unknown opcodes, response back-pressure and reset during a scan.
module tb_hb_udp_responder;

    localparam int DEPTH = 16;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   s_tvalid;
    logic [143:0]           s_tdata;
    logic                   s_tready;
    logic                   m_tvalid;
    logic [143:0]           m_tdata;
    logic                   m_tready;
    logic [$clog2(DEPTH):0] occ;

    int errors = 0;
    int checks = 0;

    hb_udp_responder #(.DEPTH(DEPTH)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .s_axis_udp_req_tvalid (s_tvalid),
        .s_axis_udp_req_tdata  (s_tdata),
        .s_axis_udp_req_tready (s_tready),
        .m_axis_udp_res_tvalid (m_tvalid),
        .m_axis_udp_res_tdata  (m_tdata),
        .m_axis_udp_res_tready (m_tready),
        .occupancy             (occ)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request (called at posedge+1) and verify its response.
    task automatic do_req(input string tag, input logic [31:0] op, input logic [63:0] key,
                          input logic [15:0] addr, input logic [7:0] exp_st,
                          input logic [15:0] exp_addr, input int exp_occ, input int stall);
        int n;
        logic [143:0] exp_data;
        check({tag, " req_ready"}, 144'(s_tready), 144'(1));
        s_tvalid = 1'b1;
        s_tdata  = {32'hA5A5_5A5A, addr, key, op};
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        check({tag, " ready_low_busy"}, 144'(s_tready), 144'(0));
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!m_tvalid && n < DEPTH + 5);
        check({tag, " latency"}, 144'(n), 144'(DEPTH + 1));
        exp_data = {24'h0, exp_st, exp_addr, key, op};
        check({tag, " tdata"}, m_tdata, exp_data);
        check({tag, " occupancy"}, 144'(occ), 144'(exp_occ));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check({tag, " stall_tvalid"}, 144'(m_tvalid), 144'(1));
            check({tag, " stall_tdata"}, m_tdata, exp_data);
            check({tag, " stall_req_ready"}, 144'(s_tready), 144'(0));
        end
        m_tready = 1'b1;
        @(posedge clk); #1;
        m_tready = 1'b0;
        check({tag, " tvalid_cleared"}, 144'(m_tvalid), 144'(0));
    endtask

    localparam logic [63:0] K1 = 64'hDEAD_BEEF_0000_0001;

    initial begin
        int seen;
        rst_n    = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        m_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset req_ready", 144'(s_tready), 144'(0));
        check("reset tvalid", 144'(m_tvalid), 144'(0));
        check("reset tdata", m_tdata, 144'(0));
        check("reset occupancy", 144'(occ), 144'(0));
        rst_n = 1'b1;
        #1;
        check("release req_ready", 144'(s_tready), 144'(1));
        @(posedge clk); #1;

        // Basic insert / duplicate / lookup / delete.
        do_req("insert_k1",   32'd0, K1, 16'h0042, 8'h01, 16'h0042, 1, 0);
        do_req("dup_insert",  32'd0, K1, 16'h0043, 8'h00, 16'h0043, 1, 0);
        do_req("lookup_k1",   32'd2, K1, 16'h1234, 8'h01, 16'h0042, 1, 0);
        do_req("delete_k1",   32'd1, K1, 16'h0000, 8'h01, 16'h0042, 0, 0);
        do_req("delete_miss", 32'd1, K1, 16'h0000, 8'h00, 16'h0000, 0, 0);
        do_req("lookup_miss", 32'd2, K1, 16'h0999, 8'h00, 16'h0999, 0, 0);

        // Back-to-back insert then delete of the same key.
        do_req("b2b_insert",  32'd0, K1, 16'h0055, 8'h01, 16'h0055, 1, 0);
        do_req("b2b_delete",  32'd1, K1, 16'h0000, 8'h01, 16'h0055, 0, 0);

        // Opcode compared on all 32 bits.
        do_req("op_0101",     32'h0000_0101, K1, 16'h0011, 8'h00, 16'h0011, 0, 0);

        // Fill the table; each key lands at the index it was inserted in.
        for (int i = 0; i < DEPTH; i++)
            do_req("fill", 32'd0, 64'(64'h1000 + i), 16'(16'h0100 + i), 8'h01,
                   16'(16'h0100 + i), i + 1, 0);
        do_req("insert_full",  32'd0, 64'h2000, 16'h0200, 8'h00, 16'h0200, DEPTH, 0);
        do_req("delete_idx3",  32'd1, 64'h1003, 16'h0000, 8'h01, 16'h0103, DEPTH - 1, 0);
        do_req("reinsert",     32'd0, 64'h3000, 16'h0333, 8'h01, 16'h0333, DEPTH, 0);
        do_req("lookup_new",   32'd2, 64'h3000, 16'h0000, 8'h01, 16'h0333, DEPTH, 0);
        do_req("lookup_gone",  32'd2, 64'h1003, 16'h0abc, 8'h00, 16'h0abc, DEPTH, 0);

        // Back-pressure on the response channel, then an unknown opcode.
        do_req("stall_lookup", 32'd2, 64'h1005, 16'h0000, 8'h01, 16'h0105, DEPTH, 10);
        do_req("op_5",         32'd5, 64'h1005, 16'h0777, 8'h00, 16'h0777, DEPTH, 0);
        do_req("after_op_5",   32'd2, 64'h1005, 16'h0000, 8'h01, 16'h0105, DEPTH, 0);

        // Reset in the middle of an insert scan.
        do_req("clear_one",    32'd1, 64'h1000, 16'h0000, 8'h01, 16'h0100, DEPTH - 1, 0);
        check("rst_test req_ready", 144'(s_tready), 144'(1));
        s_tvalid = 1'b1;
        s_tdata  = {32'h0, 16'h0444, 64'h4000, 32'd0};
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_reset req_ready", 144'(s_tready), 144'(0));
        check("mid_reset occupancy", 144'(occ), 144'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("mid_release req_ready", 144'(s_tready), 144'(1));
        seen = 0;
        for (int i = 0; i < DEPTH + 5; i++) begin
            @(posedge clk); #1;
            if (m_tvalid) seen++;
        end
        check("no_response_after_reset", 144'(seen), 144'(0));
        check("occupancy_after_reset", 144'(occ), 144'(0));
        do_req("lookup_aborted", 32'd2, 64'h4000, 16'h0001, 8'h00, 16'h0001, 0, 0);
        do_req("lookup_cleared", 32'd2, 64'h1005, 16'h0002, 8'h00, 16'h0002, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
